// File: rtl/soc_mgmt_clk_freq_seq.sv
// Frequency-change sequencer for one PLL and its divided clock channels.
// Parks channels on REF_CLK, relocks the PLL, reloads divisors, then unparks.
module soc_mgmt_clk_freq_seq #(
    parameter int NumChannels  = 6,
    parameter int DivWidth     = 4,
    parameter int PllMWidth    = 10,
    parameter int PllPWidth    = 6,
    parameter int PllSWidth    = 3,
    parameter int SyncStages   = 3,
    parameter int ResetCycles  = 32,
    parameter int LockTimeout  = 4096,
    parameter int MuxTimeout   = 64,
    parameter int SettleCycles = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_req_valid,
    output logic                            o_req_ready,
    input  logic [NumChannels-1:0]          i_req_ch_mask,
    input  logic [PllMWidth-1:0]            i_req_pll_m,
    input  logic [PllPWidth-1:0]            i_req_pll_p,
    input  logic [PllSWidth-1:0]            i_req_pll_s,
    input  logic [NumChannels*DivWidth-1:0] i_req_div,
    output logic                            o_rsp_valid,
    input  logic                            i_rsp_ready,
    output logic [1:0]                      o_rsp_error,
    output logic                            o_pll_resetb,
    output logic [PllMWidth-1:0]            o_pll_m,
    output logic [PllPWidth-1:0]            o_pll_p,
    output logic [PllSWidth-1:0]            o_pll_s,
    input  logic                            i_pll_lock,
    output logic [NumChannels-1:0]          o_div_mux_select,
    input  logic [NumChannels-1:0]          i_div_mux_active,
    output logic [NumChannels*DivWidth-1:0] o_divisor,
    output logic [NumChannels-1:0]          o_div_update,
    output logic                            o_busy,
    output logic                            o_lock_lost
);

    localparam int Max01    = (ResetCycles > LockTimeout) ? ResetCycles : LockTimeout;
    localparam int Max23    = (MuxTimeout > SettleCycles) ? MuxTimeout : SettleCycles;
    localparam int TimerMax = (Max01 > Max23) ? Max01 : Max23;
    localparam int TimerW   = $clog2(TimerMax + 1);
    localparam int DivAllW  = NumChannels * DivWidth;

    localparam logic [TimerW-1:0] ResetLast  = TimerW'(ResetCycles - 1);
    localparam logic [TimerW-1:0] LockLast   = TimerW'(LockTimeout - 1);
    localparam logic [TimerW-1:0] MuxLast    = TimerW'(MuxTimeout - 1);
    localparam logic [TimerW-1:0] SettleLast = TimerW'(SettleCycles - 1);

    localparam logic [1:0] ErrOk     = 2'd0;
    localparam logic [1:0] ErrPark   = 2'd1;
    localparam logic [1:0] ErrLock   = 2'd2;
    localparam logic [1:0] ErrUnpark = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARK,
        ST_PLL_RST,
        ST_LOCK,
        ST_DIV_UPD,
        ST_UNPARK,
        ST_DONE
    } state_e;

    state_e                   state_q;
    logic [TimerW-1:0]        timer_q;
    logic [TimerW-1:0]        timer_d;
    logic [NumChannels-1:0]   mask_q;
    logic [PllMWidth-1:0]     req_m_q;
    logic [PllPWidth-1:0]     req_p_q;
    logic [PllSWidth-1:0]     req_s_q;
    logic [DivAllW-1:0]       req_div_q;
    logic [DivAllW-1:0]       req_div_d;
    logic [DivAllW-1:0]       divisor_q;
    logic [DivAllW-1:0]       divisor_d;
    logic                     ready_q;
    logic                     rsp_valid_q;
    logic [1:0]               rsp_error_q;
    logic                     busy_q;
    logic                     resetb_q;
    logic [PllMWidth-1:0]     pll_m_q;
    logic [PllPWidth-1:0]     pll_p_q;
    logic [PllSWidth-1:0]     pll_s_q;
    logic [NumChannels-1:0]   sel_q;
    logic [NumChannels-1:0]   update_q;
    logic                     lock_lost_q;
    logic                     lock_prev_q;

    logic [SyncStages-1:0]                  lock_sync_q;
    logic [SyncStages-1:0][NumChannels-1:0] act_sync_q;
    logic                                   lock_s;
    logic [NumChannels-1:0]                 act_s;
    logic                                   lock_fall;
    logic                                   park_done;
    logic                                   unpark_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_sync_q <= '0;
            act_sync_q  <= '0;
        end else begin
            lock_sync_q[0] <= i_pll_lock;
            act_sync_q[0]  <= i_div_mux_active;
            for (int i = 1; i < SyncStages; i++) begin
                lock_sync_q[i] <= lock_sync_q[i-1];
                act_sync_q[i]  <= act_sync_q[i-1];
            end
        end
    end

    assign lock_s      = lock_sync_q[SyncStages-1];
    assign act_s       = act_sync_q[SyncStages-1];
    assign lock_fall   = lock_prev_q & ~lock_s;
    assign park_done   = (act_s & mask_q) == '0;
    assign unpark_done = (act_s & mask_q) == mask_q;

    // Shared timer saturates at all-ones instead of wrapping.
    assign timer_d = (timer_q == '1) ? timer_q : timer_q + TimerW'(1);

    always_comb begin
        req_div_d = i_req_div;
        divisor_d = divisor_q;
        for (int c = 0; c < NumChannels; c++) begin
            if (i_req_div[c*DivWidth +: DivWidth] == '0) begin
                req_div_d[c*DivWidth +: DivWidth] = DivWidth'(1);
            end
            if (mask_q[c]) begin
                divisor_d[c*DivWidth +: DivWidth] = req_div_q[c*DivWidth +: DivWidth];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            mask_q      <= '0;
            req_m_q     <= '0;
            req_p_q     <= '0;
            req_s_q     <= '0;
            req_div_q   <= {NumChannels{DivWidth'(1)}};
            divisor_q   <= {NumChannels{DivWidth'(1)}};
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= ErrOk;
            busy_q      <= 1'b0;
            resetb_q    <= 1'b0;
            pll_m_q     <= '0;
            pll_p_q     <= '0;
            pll_s_q     <= '0;
            sel_q       <= '0;
            update_q    <= '0;
            lock_lost_q <= 1'b0;
            lock_prev_q <= 1'b0;
        end else begin
            lock_prev_q <= lock_s;
            update_q    <= '0;
            timer_q     <= timer_d;
            case (state_q)
                ST_IDLE: begin
                    // Lock loss outranks a same-cycle request; the request is taken next cycle.
                    if (lock_fall && resetb_q) begin
                        lock_lost_q <= 1'b1;
                        sel_q       <= '0;
                    end else if (i_req_valid && ready_q) begin
                        mask_q      <= i_req_ch_mask;
                        req_m_q     <= i_req_pll_m;
                        req_p_q     <= i_req_pll_p;
                        req_s_q     <= i_req_pll_s;
                        req_div_q   <= req_div_d;
                        lock_lost_q <= 1'b0;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        timer_q     <= '0;
                        if (i_req_ch_mask == '0) begin
                            state_q     <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= ErrOk;
                        end else begin
                            state_q <= ST_PARK;
                            sel_q   <= sel_q & ~i_req_ch_mask;
                        end
                    end
                end
                ST_PARK: begin
                    if (park_done) begin
                        state_q  <= ST_PLL_RST;
                        timer_q  <= '0;
                        resetb_q <= 1'b0;
                        pll_m_q  <= req_m_q;
                        pll_p_q  <= req_p_q;
                        pll_s_q  <= req_s_q;
                    end else if (timer_q == MuxLast) begin
                        state_q     <= ST_DONE;
                        timer_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= ErrPark;
                    end
                end
                ST_PLL_RST: begin
                    if (timer_q == ResetLast) begin
                        state_q  <= ST_LOCK;
                        timer_q  <= '0;
                        resetb_q <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (lock_s) begin
                        state_q   <= ST_DIV_UPD;
                        timer_q   <= '0;
                        divisor_q <= divisor_d;
                        update_q  <= mask_q;
                    end else if (timer_q == LockLast) begin
                        state_q     <= ST_DONE;
                        timer_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= ErrLock;
                    end
                end
                ST_DIV_UPD: begin
                    if (timer_q == SettleLast) begin
                        state_q <= ST_UNPARK;
                        timer_q <= '0;
                        sel_q   <= sel_q | mask_q;
                    end
                end
                ST_UNPARK: begin
                    if (unpark_done) begin
                        state_q     <= ST_DONE;
                        timer_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= ErrOk;
                    end else if (timer_q == MuxLast) begin
                        state_q     <= ST_DONE;
                        timer_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= ErrUnpark;
                    end
                end
                ST_DONE: begin
                    if (i_rsp_ready) begin
                        state_q     <= ST_IDLE;
                        timer_q     <= '0;
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready      = ready_q;
    assign o_rsp_valid      = rsp_valid_q;
    assign o_rsp_error      = rsp_error_q;
    assign o_pll_resetb     = resetb_q;
    assign o_pll_m          = pll_m_q;
    assign o_pll_p          = pll_p_q;
    assign o_pll_s          = pll_s_q;
    assign o_div_mux_select = sel_q;
    assign o_divisor        = divisor_q;
    assign o_div_update     = update_q;
    assign o_busy           = busy_q;
    assign o_lock_lost      = lock_lost_q;

endmodule

// File: tb/tb_soc_mgmt_clk_freq_seq.sv
// Directed bench for soc_mgmt_clk_freq_seq with a simple PLL-lock and clock-mux model.
module tb_soc_mgmt_clk_freq_seq;

    localparam int NC = 6;
    localparam int DW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [NC-1:0]     req_mask;
    logic [9:0]        req_m;
    logic [5:0]        req_p;
    logic [2:0]        req_s;
    logic [NC*DW-1:0]  req_div;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_error;
    logic              pll_resetb;
    logic [9:0]        pll_m;
    logic [5:0]        pll_p;
    logic [2:0]        pll_s;
    logic              pll_lock;
    logic [NC-1:0]     mux_sel;
    logic [NC-1:0]     mux_act;
    logic [NC*DW-1:0]  divisor;
    logic [NC-1:0]     div_update;
    logic              busy;
    logic              lock_lost;

    logic              lock_en;
    logic              lock_drop;
    logic              lock_m;
    logic [3:0]        lk_cnt;
    logic [NC-1:0]     act_hold;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    int upd5_cnt = 0;
    int sel5_low = 0;
    int rlow_cnt = 0;
    logic [NC-1:0] upd_last = '0;

    always #5 clk = ~clk;

    soc_mgmt_clk_freq_seq dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_ch_mask(req_mask),
        .i_req_pll_m(req_m), .i_req_pll_p(req_p), .i_req_pll_s(req_s), .i_req_div(req_div),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_error(rsp_error),
        .o_pll_resetb(pll_resetb), .o_pll_m(pll_m), .o_pll_p(pll_p), .o_pll_s(pll_s),
        .i_pll_lock(pll_lock), .o_div_mux_select(mux_sel), .i_div_mux_active(mux_act),
        .o_divisor(divisor), .o_div_update(div_update), .o_busy(busy), .o_lock_lost(lock_lost)
    );

    // PLL locks a few cycles after its reset is released; muxes follow select immediately.
    always @(posedge clk) begin
        if (rst || !pll_resetb || !lock_en) begin
            lk_cnt <= 4'd0;
            lock_m <= 1'b0;
        end else if (lk_cnt < 4'd8) begin
            lk_cnt <= lk_cnt + 4'd1;
        end else begin
            lock_m <= 1'b1;
        end
    end

    assign pll_lock = lock_m & ~lock_drop;
    assign mux_act  = mux_sel | act_hold;

    always @(negedge clk) begin
        if (div_update != '0) begin
            upd_cnt++;
            upd_last = div_update;
        end
        if (div_update[5]) upd5_cnt++;
        if (!mux_sel[5]) sel5_low++;
        if (!pll_resetb) rlow_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [NC-1:0] mask, input logic [9:0] m, input logic [5:0] p,
                            input logic [2:0] s, input logic [NC*DW-1:0] div);
        req_mask  = mask;
        req_m     = m;
        req_p     = p;
        req_s     = s;
        req_div   = div;
        req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int n);
        n = 0;
        while (!rsp_valid && n < budget) begin
            tick(1);
            n++;
        end
        chk("rsp_arrive", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk("ack_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("ack_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int n;
        int base_a;
        int base_b;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_mask = '0;
        req_m = '0; req_p = '0; req_s = '0; req_div = '0;
        lock_en = 1'b1; lock_drop = 1'b0; act_hold = '0;
        tick(3);
        rst = 1'b0;
        tick(2);

        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_error", {30'd0, rsp_error}, 32'd0);
        chk("rst_resetb", {31'd0, pll_resetb}, 32'd0);
        chk("rst_pll_m", {22'd0, pll_m}, 32'd0);
        chk("rst_sel", {26'd0, mux_sel}, 32'd0);
        chk("rst_divisor", {8'd0, divisor}, 32'h111111);
        chk("rst_update", {26'd0, div_update}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_lock_lost", {31'd0, lock_lost}, 32'd0);

        // Empty mask completes immediately without touching the PLL.
        send_req(6'b000000, 10'd7, 6'd1, 3'd1, 24'h0);
        chk("m0_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("m0_error", {30'd0, rsp_error}, 32'd0);
        chk("m0_busy", {31'd0, busy}, 32'd1);
        chk("m0_ready", {31'd0, req_ready}, 32'd0);
        chk("m0_resetb", {31'd0, pll_resetb}, 32'd0);
        chk("m0_pll_m", {22'd0, pll_m}, 32'd0);
        ack();

        // Basic change on channels 0 and 1.
        base_a = upd_cnt;
        send_req(6'b000011, 10'd100, 6'd2, 3'd1, 24'h654723);
        n = 0;
        while (pll_m != 10'd100 && n < 20) begin tick(1); n++; end
        chk("t1_pll_m", {22'd0, pll_m}, 32'd100);
        chk("t1_pll_p", {26'd0, pll_p}, 32'd2);
        chk("t1_pll_s", {29'd0, pll_s}, 32'd1);
        chk("t1_resetb_low", {31'd0, pll_resetb}, 32'd0);
        n = 0;
        while (!pll_resetb && n < 100) begin tick(1); n++; end
        chk("t1_reset_len", n, 32'd32);
        wait_rsp(300, n);
        chk("t1_error", {30'd0, rsp_error}, 32'd0);
        chk("t1_sel", {26'd0, mux_sel}, 32'h03);
        chk("t1_divisor", {8'd0, divisor}, 32'h111123);
        chk("t1_upd_cnt", upd_cnt - base_a, 32'd1);
        chk("t1_upd_mask", {26'd0, upd_last}, 32'h03);
        rsp_ready = 1'b0;
        tick(3);
        chk("t1_rsp_held", {31'd0, rsp_valid}, 32'd1);
        chk("t1_err_held", {30'd0, rsp_error}, 32'd0);
        ack();

        // Channel 5 brought up, then left untouched by a channel-0 change.
        send_req(6'b100000, 10'd3, 6'd1, 3'd1, 24'h900000);
        wait_rsp(300, n);
        chk("t4a_error", {30'd0, rsp_error}, 32'd0);
        chk("t4a_sel", {26'd0, mux_sel}, 32'h23);
        chk("t4a_divisor", {8'd0, divisor}, 32'h911123);
        ack();
        base_a = sel5_low;
        base_b = upd5_cnt;
        send_req(6'b000001, 10'd20, 6'd3, 3'd2, 24'hF00000);
        wait_rsp(300, n);
        chk("t4_error", {30'd0, rsp_error}, 32'd0);
        chk("t4_sel", {26'd0, mux_sel}, 32'h23);
        chk("t4_divisor", {8'd0, divisor}, 32'h911121);
        chk("t4_ch5_sel_low", sel5_low - base_a, 32'd0);
        chk("t4_ch5_strobe", upd5_cnt - base_b, 32'd0);
        chk("t4_upd_mask", {26'd0, upd_last}, 32'h01);
        ack();

        // One-cycle lock drop in IDLE, with a request landing on the detection cycle.
        lock_drop = 1'b1;
        tick(1);
        lock_drop = 1'b0;
        tick(2);
        req_mask = 6'b000001; req_m = 10'd33; req_p = 6'd4; req_s = 3'd3; req_div = 24'h000005;
        req_valid = 1'b1;
        tick(1);
        chk("t5_lock_lost", {31'd0, lock_lost}, 32'd1);
        chk("t5_sel_forced", {26'd0, mux_sel}, 32'd0);
        chk("t5_ready", {31'd0, req_ready}, 32'd1);
        chk("t5_not_busy", {31'd0, busy}, 32'd0);
        tick(1);
        req_valid = 1'b0;
        chk("t5_accept_busy", {31'd0, busy}, 32'd1);
        chk("t5_lost_cleared", {31'd0, lock_lost}, 32'd0);
        chk("t5_accept_ready", {31'd0, req_ready}, 32'd0);
        wait_rsp(300, n);
        chk("t5_error", {30'd0, rsp_error}, 32'd0);
        chk("t5_sel", {26'd0, mux_sel}, 32'h01);
        chk("t5_divisor", {8'd0, divisor}, 32'h911125);
        ack();

        // Park timeout: channel 0 mux never leaves DIV_CLK.
        act_hold = 6'b000001;
        base_a = rlow_cnt;
        send_req(6'b000001, 10'd77, 6'd5, 3'd4, 24'h000008);
        wait_rsp(200, n);
        chk("t3_park_time", n, 32'd64);
        chk("t3_error", {30'd0, rsp_error}, 32'd1);
        chk("t3_pll_m", {22'd0, pll_m}, 32'd33);
        chk("t3_pll_p", {26'd0, pll_p}, 32'd4);
        chk("t3_pll_s", {29'd0, pll_s}, 32'd3);
        chk("t3_resetb_low", rlow_cnt - base_a, 32'd0);
        chk("t3_sel", {26'd0, mux_sel}, 32'd0);
        chk("t3_divisor", {8'd0, divisor}, 32'h911125);
        ack();
        act_hold = '0;

        // Lock timeout: PLL never locks.
        lock_en = 1'b0;
        base_a = upd_cnt;
        send_req(6'b000010, 10'd200, 6'd6, 3'd5, 24'h0000A0);
        n = 0;
        while (pll_resetb && n < 20) begin tick(1); n++; end
        chk("t2_resetb_fell", {31'd0, pll_resetb}, 32'd0);
        n = 0;
        while (!pll_resetb && n < 100) begin tick(1); n++; end
        chk("t2_resetb_rose", {31'd0, pll_resetb}, 32'd1);
        wait_rsp(5000, n);
        chk("t2_lock_time", n, 32'd4096);
        chk("t2_error", {30'd0, rsp_error}, 32'd2);
        chk("t2_sel", {26'd0, mux_sel}, 32'd0);
        chk("t2_divisor", {8'd0, divisor}, 32'h911125);
        chk("t2_no_strobe", upd_cnt - base_a, 32'd0);
        chk("t2_pll_m", {22'd0, pll_m}, 32'd200);
        ack();
        tick(10);
        chk("t2_no_lock_lost", {31'd0, lock_lost}, 32'd0);

        // Reset asserted while waiting for lock.
        send_req(6'b000001, 10'd150, 6'd1, 3'd1, 24'h000004);
        n = 0;
        while (pll_resetb && n < 20) begin tick(1); n++; end
        n = 0;
        while (!pll_resetb && n < 100) begin tick(1); n++; end
        tick(5);
        chk("t6_in_lock_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick(1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_ready", {31'd0, req_ready}, 32'd1);
        chk("t6_resetb", {31'd0, pll_resetb}, 32'd0);
        chk("t6_pll_m", {22'd0, pll_m}, 32'd0);
        chk("t6_sel", {26'd0, mux_sel}, 32'd0);
        chk("t6_divisor", {8'd0, divisor}, 32'h111111);
        chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_rsp_error", {30'd0, rsp_error}, 32'd0);
        rst = 1'b0;
        tick(2);
        chk("t6_ready_after", {31'd0, req_ready}, 32'd1);
        chk("t6_busy_after", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
